alu_instr_decoder: RTL
======================

# alu_instr_decoder

Pipelined decode stage that accepts 32-bit RV32I instruction words over a valid/ready handshake and produces the 4-bit ALU operation code, register indices and immediate consumed by the integer ALU. It covers the R-type OP (0110011) and I-type OP-IMM (0010011) classes and flags everything else as illegal. It sits between fetch and the register-read/ALU stage. A 2-entry skid buffer gives full throughput with a registered upstream ready.

## Interface
- No parameters.
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept; decoded from state register only.
- i_instr  input  32  instruction word.
- o_valid  output  1  decoded entry available downstream.
- i_ready  input  1  downstream accepts the entry.
- o_op  output  4  ALU op: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001.
- o_rd, o_rs1, o_rs2  output  5 each  instr[11:7], [19:15], [24:20].
- o_imm  output  32  immediate, see Operation.
- o_use_imm  output  1  1 for OP-IMM: operand B is o_imm.
- o_illegal  output  1  instruction not in supported set.

## Operation
- Accept when i_valid && o_ready; emit when o_valid && i_ready.
- funct3 map: 000 add (R: funct7 0100000 → sub), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- R-type: funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
- OP-IMM: funct3 001 requires funct7 0000000; funct3 101 requires 0000000 (srl) or 0100000 (sra); other funct3 ignore instr[31:25].
- o_imm: OP-IMM shifts → zero-extended instr[24:20]; other OP-IMM → sign-extended instr[31:20]; R-type → 0.
- Illegal (any other opcode or bad funct7): o_illegal=1, o_op=0000, o_use_imm=0, o_imm=0; index fields still passed through. Entry still flows downstream in order.
- Skid buffer states: EMPTY (0 entries), ONE, FULL (2 entries). o_ready = (state != FULL). o_valid = (state != EMPTY). Output always shows oldest entry.
- Transitions: EMPTY+accept→ONE; ONE+accept−emit→FULL; ONE+emit−accept→EMPTY; ONE+both→ONE; FULL+emit→ONE (skid entry moves to output); FULL never accepts.
- Outputs stable while o_valid && !i_ready.

## Timing
- Latency: accepted in cycle N → o_valid with decoded fields in cycle N+1.
- Throughput: 1 instruction/cycle while i_ready held high.
- No combinational path from i_ready or i_valid to o_ready.
- Reset: state EMPTY; o_valid=0, o_ready=1 from first cycle after reset; all data outputs 0. Nothing accepted while i_rst is high.
- Reset mid-stream: all buffered entries discarded, no emission next cycle.
- Data outputs when o_valid=0: hold last value (don't-care for consumers).

## Structure
- Package alu_pkg: ALU op localparams (ALU_ADD…ALU_AND), opcode constants OPC_OP, OPC_OP_IMM, state encoding.
- Sub-module alu_decode_comb: purely combinational instr → {op, rd, rs1, rs2, imm, use_imm, illegal}; instantiated once at the input; top holds the two entry registers and state FSM.

## Test plan
- 0x002081B3 (add x3,x1,x2) → next cycle o_op=0000, rd=3, rs1=1, rs2=2, use_imm=0, illegal=0.
- 0x407302B3 (sub x5,x6,x7) → o_op=0001, rd=5; 0xFFF00093 (addi x1,x0,-1) → o_op=0000, o_imm=0xFFFFFFFF, use_imm=1.
- 0x40315113 (srai x2,x2,3) → o_op=0111, o_imm=3, use_imm=1; same with funct7 0000000 (0x00315113) → 0110.
- 0x0000006F (jal) and 0x022081B3 (mul) → o_illegal=1, o_op=0000, delivered in order with neighbours.
- Stream 5 instrs, i_ready low 3 cycles: o_ready drops after 2 accepted, no loss/duplication, order preserved, 1/cycle after release.
- Assert i_rst with FULL buffer → next cycle o_valid=0, o_ready=1; previously buffered entries never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU instruction decode stage:
// ALU op codes, RV32I opcode/funct7 values, skid-buffer states and the decoded entry.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_entry_t;

  // alt selects sub (funct3 000) or sra (funct3 101); ignored for the other funct3 values
  function automatic logic [3:0] f3_to_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I OP / OP-IMM decoder producing one decoded entry.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_entry_t  entry
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       imm_legal_s;
  logic       imm_shift_s;

  assign opcode_s    = instr[6:0];
  assign funct3_s    = instr[14:12];
  assign funct7_s    = instr[31:25];
  assign imm_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

  // OP-IMM funct7 legality: only the shift encodings constrain instr[31:25]
  always_comb begin
    imm_legal_s = 1'b1;
    case (funct3_s)
      3'b001:  imm_legal_s = (funct7_s == F7_BASE);
      3'b101:  imm_legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
      default: imm_legal_s = 1'b1;
    endcase
  end

  // Main decode; index fields pass through even for illegal instructions
  always_comb begin
    entry         = '0;
    entry.rd      = instr[11:7];
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.illegal = 1'b1;
    case (opcode_s)
      OPC_OP: begin
        if ((funct7_s == F7_BASE) ||
            ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)))) begin
          entry.op      = f3_to_op(funct3_s, funct7_s[5]);
          entry.illegal = 1'b0;
        end else begin
          entry.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (imm_legal_s) begin
          entry.op      = f3_to_op(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
          entry.use_imm = 1'b1;
          entry.illegal = 1'b0;
          if (imm_shift_s) begin
            entry.imm = {27'd0, instr[24:20]};
          end else begin
            entry.imm = {{20{instr[31]}}, instr[31:20]};
          end
        end else begin
          entry.illegal = 1'b1;
        end
      end
      default: entry.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_instr_decoder.sv
// Decode stage with a 2-entry skid buffer: out_r is always the oldest entry,
// skid_r catches the one accepted while the output is stalled.
module alu_instr_decoder
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_op,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output logic        o_use_imm,
  output logic        o_illegal
);

  dec_entry_t dec_s;
  dec_entry_t out_r;
  dec_entry_t skid_r;
  state_t     state_r;
  logic       accept_s;
  logic       emit_s;

  alu_decode_comb u_decode (
    .instr (i_instr),
    .entry (dec_s)
  );

  assign accept_s = i_valid && (state_r != ST_FULL);
  assign emit_s   = i_ready && (state_r != ST_EMPTY);

  // Skid-buffer FSM and entry registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_EMPTY;
      out_r   <= '0;
      skid_r  <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            out_r   <= dec_s;
            state_r <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({accept_s, emit_s})
            2'b10: begin
              skid_r  <= dec_s;
              state_r <= ST_FULL;
            end
            2'b01:   state_r <= ST_EMPTY;
            2'b11:   out_r   <= dec_s;
            default: state_r <= ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (emit_s) begin
            out_r   <= skid_r;
            state_r <= ST_ONE;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  assign o_ready   = (state_r != ST_FULL);
  assign o_valid   = (state_r != ST_EMPTY);
  assign o_op      = out_r.op;
  assign o_rd      = out_r.rd;
  assign o_rs1     = out_r.rs1;
  assign o_rs2     = out_r.rs2;
  assign o_imm     = out_r.imm;
  assign o_use_imm = out_r.use_imm;
  assign o_illegal = out_r.illegal;

endmodule
